// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO default geometry plus pointer-width and wrap-increment helpers.
package fifo_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
    // Wraps at depth-1 rather than 2^width so non-power-of-two depths work.
    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction
endpackage

// File: rtl/onehot_decode.sv
// onehot_decode: enabled one-hot decoder; codes at or beyond OUT_N select nothing.
module onehot_decode #(
    parameter int IN_W  = 4,
    parameter int OUT_N = 16
) (
    input  logic [IN_W-1:0]  code_i,
    input  logic             en_i,
    output logic [OUT_N-1:0] sel_o
);
    for (genvar i = 0; i < OUT_N; i++) begin : g_sel
        assign sel_o[i] = en_i && (code_i == IN_W'(i));
    end
endmodule

// File: rtl/fifo_onehot_regfile.sv
// fifo_onehot_regfile: register-file FIFO with one-hot write select, registered read port and sticky errors.
// Define FIFO_ALMOST_FLAGS_EN to add AF_LVL/AE_LVL and the almost_full/almost_empty outputs.
module fifo_onehot_regfile
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = ptr_w(DEPTH)
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    output logic              almost_full,
    output logic              almost_empty
`endif
);
    localparam int CW = ADDR_W + 1;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [DEPTH-1:0]  wr_sel;
    logic              wr_acc, rd_acc;
    logic              full_q, empty_q, rd_valid_q, overflow_q, underflow_q;

    always_comb begin
        wr_acc   = wr_en && !full_q;
        rd_acc   = rd_en && !empty_q;
        wr_ptr_d = wr_acc ? ADDR_W'(ptr_inc(int'(wr_ptr_q), DEPTH)) : wr_ptr_q;
        rd_ptr_d = rd_acc ? ADDR_W'(ptr_inc(int'(rd_ptr_q), DEPTH)) : rd_ptr_q;
        count_d  = (wr_acc && !rd_acc) ? count_q + CW'(1) :
                   (rd_acc && !wr_acc) ? count_q - CW'(1) : count_q;
    end

    onehot_decode #(.IN_W(ADDR_W), .OUT_N(DEPTH)) u_wr_dec (
        .code_i(wr_ptr_q),
        .en_i  (wr_acc),
        .sel_o (wr_sel)
    );

    // Storage is intentionally left out of reset; the pointers define validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++)
            if (wr_sel[i]) mem_q[i] <= wr_data;
    end

`ifdef FIFO_ALMOST_FLAGS_EN
    logic af_q, ae_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            af_q <= 1'b0;
            ae_q <= 1'b1;
        end else begin
            af_q <= count_d >= CW'(AF_LVL);
            ae_q <= count_d <= CW'(AE_LVL);
        end
    end
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= count_d == CW'(DEPTH);
            empty_q     <= count_d == '0;
            rd_valid_q  <= rd_acc;
            if (rd_acc) rd_data_q <= mem_q[rd_ptr_q];
            overflow_q  <= overflow_q || (wr_en && full_q);
            underflow_q <= underflow_q || (rd_en && empty_q);
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
endmodule

// File: tb/tb_fifo_onehot_regfile.sv
// tb_fifo_onehot_regfile: queue-model check of a DEPTH=16 and a DEPTH=10 FIFO driven by shared stimulus.
module tb_fifo_onehot_regfile;
    localparam int DEP [2] = '{16, 10};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] wr_data = 8'h00;

    logic [7:0] rdd [2];
    logic [4:0] cnt [2];
    logic       rdv [2];
    logic       ful [2];
    logic       emp [2];
    logic       ovf [2];
    logic       unf [2];
`ifdef FIFO_ALMOST_FLAGS_EN
    logic       afl [2];
    logic       ael [2];
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    fifo_onehot_regfile #(.DATA_W(8), .DEPTH(16)) u_d16 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rdd[0]), .rd_valid(rdv[0]), .full(ful[0]), .empty(emp[0]),
        .count(cnt[0]), .overflow(ovf[0]), .underflow(unf[0])
`ifdef FIFO_ALMOST_FLAGS_EN
        , .almost_full(afl[0]), .almost_empty(ael[0])
`endif
    );

    fifo_onehot_regfile #(.DATA_W(8), .DEPTH(10)) u_d10 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rdd[1]), .rd_valid(rdv[1]), .full(ful[1]), .empty(emp[1]),
        .count(cnt[1]), .overflow(ovf[1]), .underflow(unf[1])
`ifdef FIFO_ALMOST_FLAGS_EN
        , .almost_full(afl[1]), .almost_empty(ael[1])
`endif
    );

    // Reference: a plain queue of words per FIFO, plus expected read port and sticky flags.
    bit [7:0] mq [2][$];
    bit [7:0] erd [2];
    bit       erv [2];
    bit       eov [2];
    bit       eun [2];
    int       n;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mq[k].delete();
                erd[k] = 8'h00;
                erv[k] = 1'b0;
                eov[k] = 1'b0;
                eun[k] = 1'b0;
            end else begin
                n = mq[k].size();
                erv[k] = 1'b0;
                if (wr_en && n == DEP[k]) eov[k] = 1'b1;
                if (rd_en && n == 0) eun[k] = 1'b1;
                if (rd_en && n > 0) begin
                    erd[k] = mq[k].pop_front();
                    erv[k] = 1'b1;
                end
                if (wr_en && n < DEP[k]) mq[k].push_back(wr_data);
            end
        end
        if (rst) chk_en = 1'b1;
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[d%0d] t=%0t got=%0h expected=%0h", nm, DEP[k], $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("count", k, 32'(cnt[k]), 32'(mq[k].size()));
                chk("full", k, 32'(ful[k]), 32'(mq[k].size() == DEP[k]));
                chk("empty", k, 32'(emp[k]), 32'(mq[k].size() == 0));
                chk("rd_valid", k, 32'(rdv[k]), 32'(erv[k]));
                chk("rd_data", k, 32'(rdd[k]), 32'(erd[k]));
                chk("overflow", k, 32'(ovf[k]), 32'(eov[k]));
                chk("underflow", k, 32'(unf[k]), 32'(eun[k]));
`ifdef FIFO_ALMOST_FLAGS_EN
                chk("almost_full", k, 32'(afl[k]), 32'(mq[k].size() >= DEP[k] - 2));
                chk("almost_empty", k, 32'(ael[k]), 32'(mq[k].size() <= 2));
`endif
            end
        end
    end

    task automatic cyc(input bit r, input bit w, input bit rd, input logic [7:0] d);
        @(negedge clk);
        rst = r;
        wr_en = w;
        rd_en = rd;
        wr_data = d;
    endtask

    initial begin
        cyc(1, 0, 0, 8'h00);
        cyc(0, 0, 0, 8'h00);
        chk("lit_reset_count", 0, 32'(cnt[0]), 32'd0);
        chk("lit_reset_empty", 0, 32'(emp[0]), 32'd1);
        chk("lit_reset_rd_data", 0, 32'(rdd[0]), 32'd0);

        for (int i = 0; i < 17; i++) cyc(0, 1, 0, 8'(i));
        cyc(0, 0, 0, 8'h00);
        chk("lit_fill_count", 0, 32'(cnt[0]), 32'd16);
        chk("lit_fill_full", 0, 32'(ful[0]), 32'd1);
        chk("lit_fill_overflow", 0, 32'(ovf[0]), 32'd1);
        chk("lit_fill_count", 1, 32'(cnt[1]), 32'd10);

        cyc(0, 0, 1, 8'h00);
        cyc(0, 0, 0, 8'h00);
        chk("lit_first_pop", 0, 32'(rdd[0]), 32'h00);
        chk("lit_first_valid", 0, 32'(rdv[0]), 32'd1);
        cyc(0, 0, 0, 8'h00);
        chk("lit_valid_pulse", 0, 32'(rdv[0]), 32'd0);
        for (int i = 1; i < 17; i++) cyc(0, 0, 1, 8'h00);
        cyc(0, 0, 0, 8'h00);
        chk("lit_drain_last", 0, 32'(rdd[0]), 32'h0F);
        chk("lit_drain_empty", 0, 32'(emp[0]), 32'd1);
        chk("lit_drain_underflow", 0, 32'(unf[0]), 32'd1);
        chk("lit_drain_last", 1, 32'(rdd[1]), 32'h09);

        cyc(1, 0, 0, 8'h00);
        for (int i = 0; i < 25; i++) begin
            cyc(0, 1, 0, 8'(i));
            cyc(0, 0, 1, 8'h00);
        end
        cyc(0, 0, 0, 8'h00);
        chk("lit_wrap_last", 1, 32'(rdd[1]), 32'd24);

        cyc(1, 0, 0, 8'h00);
        cyc(0, 1, 1, 8'h77);
        cyc(0, 0, 0, 8'h00);
        chk("lit_empty_both_count", 0, 32'(cnt[0]), 32'd1);
        chk("lit_empty_both_underflow", 0, 32'(unf[0]), 32'd1);
        chk("lit_empty_both_valid", 0, 32'(rdv[0]), 32'd0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 8'h40 + 8'(i));
        for (int i = 0; i < 20; i++) cyc(0, 1, 1, 8'h50 + 8'(i));
        cyc(0, 0, 0, 8'h00);
        chk("lit_steady_count", 0, 32'(cnt[0]), 32'd5);
        chk("lit_steady_data", 0, 32'(rdd[0]), 32'h5E);

        for (int i = 0; i < 11; i++) cyc(0, 1, 0, 8'h80 + 8'(i));
        cyc(0, 1, 1, 8'hEE);
        cyc(0, 0, 0, 8'h00);
        chk("lit_full_both_count", 0, 32'(cnt[0]), 32'd15);
        chk("lit_full_both_overflow", 0, 32'(ovf[0]), 32'd1);

        cyc(1, 0, 0, 8'h00);
        for (int i = 0; i < 7; i++) cyc(0, 1, 0, 8'h10 + 8'(i));
        cyc(1, 1, 1, 8'h33);
        cyc(0, 0, 0, 8'h00);
        chk("lit_midreset_count", 0, 32'(cnt[0]), 32'd0);
        chk("lit_midreset_empty", 0, 32'(emp[0]), 32'd1);
        chk("lit_midreset_valid", 0, 32'(rdv[0]), 32'd0);
        cyc(0, 1, 0, 8'hA5);
        cyc(0, 0, 1, 8'h00);
        cyc(0, 0, 0, 8'h00);
        chk("lit_midreset_data", 0, 32'(rdd[0]), 32'hA5);

        for (int i = 0; i < 4000; i++) begin
            int wp;
            wp = ((i / 150) % 2 == 0) ? 75 : 30;
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 99) < wp,
                $urandom_range(0, 99) < 50, 8'($urandom));
        end
        cyc(0, 0, 0, 8'h00);
        cyc(0, 0, 0, 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
